// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank write sequencer.
package regbank_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    localparam int unsigned PORT_WB  = 0;
    localparam int unsigned PORT_DBG = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
module rr_arb2
    import regbank_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            unique case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end

        // Priority passes to the port that did not just win.
        ptr_d = ptr_q;
        if (grant_o[PORT_WB]) begin
            ptr_d = 1'b1;
        end else if (grant_o[PORT_DBG]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regbank_write_sequencer.sv
// Owns the register bank write port: zero-clears every register after reset,
// then arbitrates writeback and debug writes onto the port.
module regbank_write_sequencer #(
    parameter int unsigned NUM_REGS     = regbank_pkg::NUM_REGS,
    parameter int unsigned ADDR_W       = regbank_pkg::ADDR_W,
    parameter int unsigned DATA_W       = regbank_pkg::DATA_W,
    parameter bit          ZERO_PROTECT = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic [ADDR_W-1:0] rb_write_addr,
    output logic [DATA_W-1:0] rb_write_data,
    output logic              rb_reg_write,
    output logic              init_done
);
    import regbank_pkg::*;

    // Counter runs one past the last address so the sweep end is a plain compare.
    localparam logic [ADDR_W:0] SweepEnd = (ADDR_W + 1)'(NUM_REGS);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;

    logic [1:0]        grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_arb (
        .clk_i   (clock),
        .rst_i   (reset),
        .req_i   (req_valid),
        .en_i    (state_q == StRun),
        .grant_o (grant)
    );

    assign sel_addr = grant[PORT_DBG] ? req_addr1 : req_addr0;
    assign sel_data = grant[PORT_DBG] ? req_data1 : req_data0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;

        case (state_q)
            StInit: begin
                if (cnt_q == SweepEnd) begin
                    state_d = StRun;
                    done_d  = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = cnt_q[ADDR_W-1:0];
                    data_d = '0;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (|grant) begin
                    addr_d = sel_addr;
                    data_d = sel_data;
                    we_d   = !(ZERO_PROTECT && (sel_addr == '0));
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign req_ready     = grant;
    assign rb_write_addr = addr_q;
    assign rb_write_data = data_q;
    assign rb_reg_write  = we_q;
    assign init_done     = done_q;

endmodule

// File: tb/tb_regbank_write_sequencer.sv
// Directed bench for regbank_write_sequencer with a cycle-level reference model.
module tb_regbank_write_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [4:0]  req_addr0 = '0;
    logic [4:0]  req_addr1 = '0;
    logic [31:0] req_data0 = '0;
    logic [31:0] req_data1 = '0;
    logic [1:0]  req_ready;
    logic [4:0]  rb_write_addr;
    logic [31:0] rb_write_data;
    logic        rb_reg_write;
    logic        init_done;

    regbank_write_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr0     (req_addr0),
        .req_addr1     (req_addr1),
        .req_data0     (req_data0),
        .req_data1     (req_data1),
        .req_ready     (req_ready),
        .rb_write_addr (rb_write_addr),
        .rb_write_data (rb_write_data),
        .rb_reg_write  (rb_reg_write),
        .init_done     (init_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle number since reset release drives the sweep;
    // after the sweep, a fair two-way pick decides which request is written.
    int          m_cyc;
    bit          m_ptr;
    logic [1:0]  m_g;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_done;

    function automatic logic [1:0] pick(input logic [1:0] v, input bit p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_cyc = 0; m_ptr = 1'b0;
            e_we = 1'b0; e_addr = '0; e_data = '0; e_done = 1'b0;
        end else begin
            m_g = e_done ? pick(req_valid, m_ptr) : 2'b00;
            m_cyc++;
            if (m_cyc <= 32) begin
                e_we = 1'b1; e_addr = 5'(m_cyc - 1); e_data = '0;
            end else if (!e_done) begin
                e_we = 1'b0; e_done = 1'b1;
            end else if (m_g != 2'b00) begin
                e_addr = m_g[1] ? req_addr1 : req_addr0;
                e_data = m_g[1] ? req_data1 : req_data0;
                e_we   = (e_addr != 5'd0);
                m_ptr  = m_g[0];
            end else begin
                e_we = 1'b0;
            end
        end
    endtask

    always @(posedge clock or posedge reset) model_step();

    always @(negedge clock) begin
        if (chk_en) begin
            check("cycle_outputs",
                  {23'd0, req_ready, rb_reg_write, init_done, rb_write_addr, rb_write_data},
                  {23'd0, (e_done ? pick(req_valid, m_ptr) : 2'b00), e_we, e_done, e_addr, e_data});
        end
    end

    // Downstream bank and observation monitors.
    logic [31:0] bank [32];
    always @(posedge clock) if (rb_reg_write === 1'b1) bank[rb_write_addr] <= rb_write_data;

    int         init_wr_cnt = 0;
    int         first_rdy = -1;
    logic [4:0] wr_log[$];
    always @(negedge clock) begin
        if (!reset) begin
            if (rb_reg_write && !init_done) init_wr_cnt++;
            if (req_ready != 2'b00 && first_rdy < 0) first_rdy = m_cyc;
            if (rb_reg_write && init_done) wr_log.push_back(rb_write_addr);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Holds the request until it is accepted, then drops valid.
    task automatic accept(input int p, output bit ok);
        bit hs;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            hs = req_valid[p] & req_ready[p];
            @(posedge clock);
            #1;
            if (hs) begin
                req_valid[p] = 1'b0;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_bank_zero(input string name, input int skip);
        int bad = 0;
        for (int r = 0; r < 32; r++) begin
            if (r != skip && bank[r] !== 32'd0) bad++;
        end
        check(name, bad, 0);
    endtask

    bit         ok;
    logic [1:0] g [4];

    initial begin
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b0;

        // Request from cycle 3 must wait out the sweep.
        repeat (3) step();
        req_addr0 = 5'd5; req_data0 = 32'hDEADBEEF; req_valid[0] = 1'b1;
        accept(0, ok);
        check("accept_p0", ok, 1);
        check("init_writes", init_wr_cnt, 32);
        check("first_ready_cycle", first_rdy, 33);
        check("init_done", init_done, 1);
        check("p0_write", {rb_reg_write, rb_write_addr, rb_write_data},
              {1'b1, 5'd5, 32'hDEADBEEF});
        step();
        check_bank_zero("bank_clear", 5);
        check("bank_r5", bank[5], 32'hDEADBEEF);

        // Protected address 0: handshake, no bank write.
        req_addr1 = 5'd0; req_data1 = 32'h1234; req_valid[1] = 1'b1;
        accept(1, ok);
        check("accept_zp", ok, 1);
        check("zp_no_write", rb_reg_write, 0);
        step();
        check("zp_r0", bank[0], 0);

        // Both ports contend; each advances its address when accepted.
        wr_log.delete();
        req_addr0 = 5'd1; req_data0 = 32'h1000_0001;
        req_addr1 = 5'd9; req_data1 = 32'h2000_0009;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            g[i] = req_ready;
            @(posedge clock);
            #1;
            if (g[i][0]) begin req_addr0++; req_data0 = 32'h1000_0000 | 32'(req_addr0); end
            if (g[i][1]) begin req_addr1++; req_data1 = 32'h2000_0000 | 32'(req_addr1); end
        end
        req_valid = 2'b00;
        repeat (2) step();
        check("arb_grants", {g[0], g[1], g[2], g[3]}, 8'b01_10_01_10);
        check("arb_log_size", wr_log.size(), 4);
        if (wr_log.size() >= 4) begin
            check("arb_issue_order", {wr_log[0], wr_log[1], wr_log[2], wr_log[3]},
                  {5'd1, 5'd9, 5'd2, 5'd10});
        end
        check("bank_r10", bank[10], 32'h2000_000A);

        // Pending write killed by asynchronous reset.
        req_addr0 = 5'd7; req_data0 = 32'h77; req_valid[0] = 1'b1;
        accept(0, ok);
        step();
        check("bank_r7", bank[7], 32'h77);
        req_data0 = 32'hAAAA5555; req_valid[0] = 1'b1;
        accept(0, ok);
        check("pending_we", rb_reg_write, 1);
        #3 reset = 1'b1;
        #1 check("async_drop", rb_reg_write, 0);
        init_wr_cnt = 0;
        repeat (2) step();
        check("pending_discarded", bank[7], 32'h77);
        @(negedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 50 && !init_done; i++) step();
        check("resweep_done", init_done, 1);
        check("resweep_writes", init_wr_cnt, 32);
        step();
        check_bank_zero("bank_reclear", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
